// File: rtl/volt_pkg.sv
// Shared constants, FSM encoding and sample payload for the voltage-to-BCD display path.
package volt_pkg;

  localparam int unsigned BIN_W      = 20;
  localparam int unsigned SMP_W      = BIN_W + 1;
  localparam int unsigned DIGITS     = 6;
  localparam int unsigned BCD_W      = 24;
  localparam int unsigned INT_DIGITS = 7;
  localparam int unsigned INT_BCD_W  = 4 * INT_DIGITS;
  localparam int unsigned SREG_W     = INT_BCD_W + BIN_W;
  localparam int unsigned SHIFT_CNT  = 20;
  localparam int unsigned CNT_W      = 5;

  localparam logic [BCD_W-1:0] BCD_SAT = 24'h999999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Sign/magnitude sample handed to the conversion engine
  typedef struct packed {
    logic             sign;
    logic [BIN_W-1:0] mag;
  } sample_t;

endpackage

// File: rtl/volt_bcd_conv_bcd_add3.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the next shift.
module bcd_add3
  import volt_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib_c
);

  assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/volt_bcd_conv.sv
// Samples sign/magnitude voltage at the display refresh rate and converts it to 6 BCD digits.
// Build option VOLT_AVG_EN: sample is the period mean instead of the tick-cycle value.
module volt_bcd_conv
  import volt_pkg::*;
#(
  parameter int unsigned DIV_LOG2 = 10
)
(
  input  logic             ad_clk,
  input  logic             sys_rst_n,
  input  logic             sign,
  input  logic [BIN_W-1:0] data,
  output logic [BCD_W-1:0] bcd,
  output logic             sign_out,
  output logic             ovf,
  output logic             bcd_valid,
  output logic             busy
);

  logic [DIV_LOG2-1:0]  r_div;
  logic                 w_tick;
  sample_t              w_sample;

  conv_state_e          r_state;
  conv_state_e          w_state_nxt;
  logic                 w_capture_c;
  logic                 w_shift_c;
  logic                 w_done_c;

  logic [CNT_W-1:0]     r_cnt;
  logic [SREG_W-1:0]    r_shift;
  logic [INT_BCD_W-1:0] w_corr;
  logic                 r_sign;

  logic [BCD_W-1:0]     r_bcd;
  logic                 r_sign_out;
  logic                 r_ovf;
  logic                 r_valid;
  logic                 r_busy;

  // Free-running refresh divider
  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_div <= '0;
    else            r_div <= r_div + DIV_LOG2'(1);
  end

  assign w_tick = &r_div;

`ifdef VOLT_AVG_EN
  localparam int unsigned ACC_W = SMP_W + DIV_LOG2;

  logic signed [SMP_W-1:0] w_cur;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [SMP_W-1:0] w_mean;

  assign w_cur  = sign ? -$signed({1'b0, data}) : $signed({1'b0, data});
  assign w_sum  = r_acc + ACC_W'(w_cur);
  // Arithmetic shift gives the floor of the mean; the result always fits the sample width
  assign w_mean = SMP_W'(w_sum >>> DIV_LOG2);

  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  r_acc <= '0;
    else if (w_tick) r_acc <= '0;
    else             r_acc <= w_sum;
  end

  assign w_sample.sign = w_mean[SMP_W-1];
  assign w_sample.mag  = BIN_W'(w_mean[SMP_W-1] ? -w_mean : w_mean);
`else
  assign w_sample.sign = sign;
  assign w_sample.mag  = data;
`endif

  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture_c = 1'b0;
    w_shift_c   = 1'b0;
    w_done_c    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_capture_c = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift_c = 1'b1;
        if (r_cnt == CNT_W'(SHIFT_CNT - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        w_done_c    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Seven digit correctors cover magnitudes up to 2**20-1 before saturation
  for (genvar gi = 0; gi < INT_DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib   (r_shift[BIN_W + 4*gi +: 4]),
      .o_nib_c (w_corr[4*gi +: 4])
    );
  end

  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
    end else if (w_capture_c) begin
      r_shift <= {INT_BCD_W'(0), w_sample.mag};
      r_cnt   <= '0;
      r_sign  <= w_sample.sign & (|w_sample.mag);
    end else if (w_shift_c) begin
      r_shift <= {w_corr, r_shift[BIN_W-1:0]} << 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers; busy stays up through the DONE cycle
  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bcd      <= '0;
      r_sign_out <= 1'b0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= w_done_c;
      r_busy  <= (w_state_nxt != IDLE) || (r_state == DONE);
      if (w_done_c) begin
        r_sign_out <= r_sign;
        if (r_shift[SREG_W-1 -: 4] != 4'd0) begin
          r_bcd <= BCD_SAT;
          r_ovf <= 1'b1;
        end else begin
          r_bcd <= r_shift[BIN_W +: BCD_W];
          r_ovf <= 1'b0;
        end
      end
    end
  end

  assign bcd       = r_bcd;
  assign sign_out  = r_sign_out;
  assign ovf       = r_ovf;
  assign bcd_valid = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_volt_bcd_conv.sv
// Scoreboard bench for volt_bcd_conv: model pushes expected display values at each refresh tick,
// monitor pops them on bcd_valid and checks timing, hold behaviour and reset abort.
module tb_volt_bcd_conv;

  localparam int unsigned D = 5;
  localparam int unsigned P = 1 << D;
  localparam int          LAT = 21;

  logic        ad_clk    = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sign      = 1'b0;
  logic [19:0] data      = '0;
  logic [23:0] bcd;
  logic        sign_out;
  logic        ovf;
  logic        bcd_valid;
  logic        busy;

  typedef struct {
    logic [23:0] bcd;
    logic        sgn;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks    = 0;
  int          failures  = 0;
  int          gcyc      = 0;
  int          last_cap  = -1000;
  longint      acc_sum   = 0;
  logic [23:0] shown_bcd = '0;
  logic        shown_sgn = 1'b0;
  logic        shown_ovf = 1'b0;

  volt_bcd_conv #(.DIV_LOG2(D)) u_dut (
    .ad_clk    (ad_clk),
    .sys_rst_n (sys_rst_n),
    .sign      (sign),
    .data      (data),
    .bcd       (bcd),
    .sign_out  (sign_out),
    .ovf       (ovf),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  always #5 ad_clk = ~ad_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Display value a signed voltage should produce
  function automatic exp_t model(input longint sample);
    exp_t   e;
    longint m;
    longint p;
    m     = (sample < 0) ? -sample : sample;
    e.sgn = (sample < 0);
    e.bcd = '0;
    if (m > 999999) begin
      e.bcd = 24'h999999;
      e.ovf = 1'b1;
    end else begin
      e.ovf = 1'b0;
      p = 1;
      for (int i = 0; i < 6; i++) begin
        e.bcd[4*i +: 4] = 4'((m / p) % 10);
        p = p * 10;
      end
    end
    return e;
  endfunction

  // Reference: every P-th clock after reset takes a sample
  initial forever begin
    @(posedge ad_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      exp_q.delete();
      gcyc     = 0;
      last_cap = -1000;
      acc_sum  = 0;
    end else begin
      longint cur;
      longint smp;
      gcyc++;
      cur     = sign ? -longint'(data) : longint'(data);
      acc_sum = acc_sum + cur;
      if (gcyc % P == 0) begin
`ifdef VOLT_AVG_EN
        smp = acc_sum / P;
        if ((acc_sum % P != 0) && (acc_sum < 0)) smp = smp - 1;
`else
        smp = cur;
`endif
        exp_q.push_back(model(smp));
        last_cap = gcyc;
        acc_sum  = 0;
      end
    end
  end

  // Monitor: timing of valid/busy, scoreboard pop, and held outputs
  initial forever begin
    @(negedge ad_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      shown_bcd = '0;
      shown_sgn = 1'b0;
      shown_ovf = 1'b0;
    end else begin
      exp_t e;
      check("bcd_valid", 32'(bcd_valid), 32'(gcyc == last_cap + LAT));
      check("busy", 32'(busy), 32'((gcyc >= last_cap) && (gcyc <= last_cap + LAT)));
      if (bcd_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          shown_bcd = e.bcd;
          shown_sgn = e.sgn;
          shown_ovf = e.ovf;
        end
      end
      check("bcd", 32'(bcd), 32'(shown_bcd));
      check("sign_out", 32'(sign_out), 32'(shown_sgn));
      check("ovf", 32'(ovf), 32'(shown_ovf));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bcd"}, 32'(bcd), 32'd0);
    check({tag, "_sign_out"}, 32'(sign_out), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_bcd_valid"}, 32'(bcd_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_period(input logic sa, input logic [19:0] da,
                            input logic sb, input logic [19:0] db);
    sign = sa;
    data = da;
    repeat (P/2) @(negedge ad_clk);
    sign = sb;
    data = db;
    repeat (P/2) @(negedge ad_clk);
  endtask

  function automatic logic [19:0] rnd_mag();
    case ($urandom_range(0, 3))
      0:       return 20'($urandom_range(0, 99));
      1:       return 20'($urandom_range(0, 999999));
      2:       return 20'($urandom_range(999990, 1048575));
      default: return 20'($urandom);
    endcase
  endfunction

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      run_period(1'($urandom), rnd_mag(), 1'($urandom), rnd_mag());
  endtask

  initial begin
    repeat (3) @(negedge ad_clk);
    #1 check_reset_outputs("reset");
    #1 sys_rst_n = 1'b1;

    run_period(1'b0, 20'd5000,    1'b0, 20'd5000);
    run_period(1'b1, 20'd123456,  1'b1, 20'd123456);
    run_period(1'b1, 20'd0,       1'b1, 20'd0);
    run_period(1'b0, 20'd999999,  1'b0, 20'd999999);
    run_period(1'b0, 20'd1048575, 1'b0, 20'd1048575);
    run_period(1'b0, 20'd100,     1'b1, 20'd40);
    run_period(1'b1, 20'd7,       1'b1, 20'd7);
    run_random(12);

    // Abort a conversion ten shifts in
    run_period(1'b0, 20'd654321, 1'b0, 20'd654321);
    repeat (10) @(negedge ad_clk);
    #2 sys_rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge ad_clk);
    #2 sys_rst_n = 1'b1;

    run_period(1'b0, 20'd5000, 1'b0, 20'd5000);
    run_random(4);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge ad_clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    @(negedge ad_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
